// File: rtl/high_speed_bus_ecc_dec_if.sv
// high_speed_bus_ecc_dec_if
//   Streaming bus between the link and the consumer, seen by the SECDED decoder.
//   Input side : in_valid / in_ready / codeword_in (39-bit SECDED codeword)
//   Output side: out_valid / out_ready / data_out (32-bit) with sec_err / ded_err tags
//   Modports: slave  - the decoder (accepts codewords, produces data)
//             master - the environment (link driver + consumer)
interface high_speed_bus_ecc_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] codeword_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        sec_err;
  logic        ded_err;

  modport slave (
    input  in_valid, codeword_in, out_ready,
    output in_ready, out_valid, data_out, sec_err, ded_err
  );

  modport master (
    output in_valid, codeword_in, out_ready,
    input  in_ready, out_valid, data_out, sec_err, ded_err
  );
endinterface

// File: rtl/high_speed_bus_ecc_dec.sv
// high_speed_bus_ecc_dec
//   Receive-side SECDED checker/corrector for the 39-bit bus codeword
//   (32 data + 6 Hamming check + 1 overall parity). Two-stage pipeline:
//   S1 registers codeword, syndrome and parity; S2 registers corrected data
//   and error flags. Saturating SEC/DED event counters.
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   bus        : stream interface (slave modport), see high_speed_bus_ecc_dec_if
//   cnt_clr    : synchronous clear of counters and log (wins over events)
//   sec_count  : corrected-error beats delivered (saturating, CNT_W bits)
//   ded_count  : uncorrectable beats delivered (saturating, CNT_W bits)
//   log_syn    : syndrome of first DED since reset/clear
//   log_cw     : raw codeword of first DED since reset/clear
// Configuration
//   ECC_ERR_LOG_EN : when defined, the first-DED log is implemented;
//                    otherwise log_syn/log_cw are tied to zero.
module high_speed_bus_ecc_dec #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  high_speed_bus_ecc_dec_if.slave bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       sec_count,
  output logic [CNT_W-1:0]       ded_count,
  output logic [5:0]             log_syn,
  output logic [38:0]            log_cw
);
  localparam int STAGES = 2;

  // Hamming syndrome over positions 1..38 (position p at bit p-1).
  function automatic logic [5:0] f_syn(input logic [38:0] cw);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1) s[k] = s[k] ^ cw[p-1];
    return s;
  endfunction

  // Data occupies the non-power-of-two positions in ascending order.
  function automatic logic [31:0] f_extract(input logic [38:0] cw);
    logic [31:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    return d;
  endfunction

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;
  logic            w_pop;

  // S1
  logic [38:0] r_s1_cw;
  logic [5:0]  r_s1_syn;
  logic        r_s1_par;

  // S2
  logic [31:0] r_s2_data;
  logic        r_s2_sec;
  logic        r_s2_ded;

  // decode
  logic [37:0] w_mask;
  logic [38:0] w_fix_cw;
  logic        w_sec;
  logic        w_ded;

  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_ded_cnt;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign w_adv         = bus.out_ready | ~r_vld_pipe[STAGES];
  assign w_pop         = r_vld_pipe[STAGES] & bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.data_out  = r_s2_data;
  assign bus.sec_err   = r_s2_sec;
  assign bus.ded_err   = r_s2_ded;
  assign sec_count     = r_sec_cnt;
  assign ded_count     = r_ded_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_cw  <= '0;
      r_s1_syn <= '0;
      r_s1_par <= 1'b0;
    end else if (w_adv) begin
      r_s1_cw  <= bus.codeword_in;
      r_s1_syn <= f_syn(bus.codeword_in);
      r_s1_par <= ^bus.codeword_in;
    end
  end

  // One-hot flip mask for syndrome positions 1..38.
  always_comb begin
    w_mask = '0;
    for (int p = 1; p <= 38; p++)
      w_mask[p-1] = (r_s1_syn == 6'(p));
  end

  always_comb begin
    w_fix_cw = r_s1_cw;
    w_sec    = 1'b0;
    w_ded    = 1'b0;
    if (r_s1_par) begin
      if (r_s1_syn == 6'd0) begin
        w_sec = 1'b1;                    // overall parity bit itself flipped
      end else if (r_s1_syn <= 6'd38) begin
        w_sec = 1'b1;
        w_fix_cw[37:0] = r_s1_cw[37:0] ^ w_mask;
      end else begin
        w_ded = 1'b1;                    // odd weight but syndrome off the end
      end
    end else if (r_s1_syn != 6'd0) begin
      w_ded = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_data <= '0;
      r_s2_sec  <= 1'b0;
      r_s2_ded  <= 1'b0;
    end else if (w_adv) begin
      r_s2_data <= f_extract(w_fix_cw);
      r_s2_sec  <= r_vld_pipe[1] & w_sec;
      r_s2_ded  <= r_vld_pipe[1] & w_ded;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_pop && r_s2_sec && !(&r_sec_cnt)) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      if (w_pop && r_s2_ded && !(&r_ded_cnt)) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
    end
  end

`ifdef ECC_ERR_LOG_EN
  // Raw codeword/syndrome ride along in S2 so the log sees the beat as it leaves.
  logic [38:0] r_s2_cw;
  logic [5:0]  r_s2_syn;
  logic        r_log_vld;
  logic [5:0]  r_log_syn;
  logic [38:0] r_log_cw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_cw  <= '0;
      r_s2_syn <= '0;
    end else if (w_adv) begin
      r_s2_cw  <= r_s1_cw;
      r_s2_syn <= r_s1_syn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_log_vld <= 1'b0;
      r_log_syn <= '0;
      r_log_cw  <= '0;
    end else if (cnt_clr) begin
      r_log_vld <= 1'b0;
      r_log_syn <= '0;
      r_log_cw  <= '0;
    end else if (w_pop && r_s2_ded && !r_log_vld) begin
      r_log_vld <= 1'b1;
      r_log_syn <= r_s2_syn;
      r_log_cw  <= r_s2_cw;
    end
  end

  assign log_syn = r_log_syn;
  assign log_cw  = r_log_cw;
`else
  assign log_syn = '0;
  assign log_cw  = '0;
`endif
endmodule
